mpadd_seq: RTL and testbench
============================

Name: mpadd_seq

Overview:
Multi-precision add/subtract sequencer. It pushes two K-word operands through a single W-bit ripple-carry adder slice, one word per cycle, least-significant word first. A registered carry links consecutive words. It sits between a requesting controller and the shared adder datapath and handles operand capture, word stepping, carry chaining and completion signalling.

Parameters:
W, 4, width of one adder slice in bits (≥2)
K, 4, number of words per operand (≥1); total operand width is W*K
IW, $clog2(K) (min 1), width of the word index counter

Ports:
clk     input   1     rising-edge clock
rst_n   input   1     asynchronous active-low reset
start   input   1     request a new operation; sampled only when busy=0
op_sub  input   1     0 = A+B, 1 = A-B; sampled with start
abort   input   1     synchronous cancel of an operation in progress
a_in    input   W*K   operand A; sampled with start
b_in    input   W*K   operand B; sampled with start
busy    output  1     operation in progress
done    output  1     one-cycle pulse when result is valid
result  output  W*K   sum or difference; held until the next accepted start
carry_out output 1    final carry; for subtraction, 1 means no borrow
overflow output 1     signed overflow of the full W*K-bit result

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, carry_out, overflow, result, index, carry register and operand registers all clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE -> RUN: when start=1 at an edge.
  - Latch a_in into opA.
  - Latch b_in into opB, or ~b_in if op_sub=1.
  - Carry register = op_sub.
  - idx=0, busy=1, result cleared to 0.
- RUN, each edge:
  - Slice computes opA[idx*W +: W] + opB[idx*W +: W] + carry.
  - Sum is written to result[idx*W +: W]; slice cout goes to the carry register.
  - idx increments.
- At the edge that writes word K-1:
  - state -> DONE, busy=0, done=1 for exactly one cycle.
  - carry_out = slice cout.
  - overflow = carry into slice MSB XOR slice cout.
- DONE -> IDLE: next edge with no start; done drops.
- Latency: start sampled at edge E0; words are written at E1..EK; done is high in the cycle after EK. Back-to-back starts give throughput of one operation per K+1 cycles.
- start while busy=1: ignored, no side effects.
- abort=1 in RUN: next edge -> IDLE, busy=0, done stays 0; result holds partial words and is undefined to the consumer. abort in IDLE/DONE: no effect. abort and start together while busy: abort wins.
- K=1: RUN lasts one cycle; done follows E1.
- idx never exceeds K-1; no wrap-around is visible.
- Reset mid-RUN: immediate return to IDLE with all outputs 0; no done pulse.
- Width rule: all arithmetic is modulo 2^(W*K); carry_out and overflow report the out-of-range conditions.

Decomposition:
- Package mpadd_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - OP_ADD=1'b0, OP_SUB=1'b1
- Sub-module add_slice (parameter W):
  - Combinational W-bit ripple-carry adder built from full-adder cells via a generate loop.
  - Ports: x, y, cin -> s, cout, c_msb (carry into the MSB, used for overflow).
  - Instantiated once in mpadd_seq.

Test Plan:
- W=4,K=4: start with A=0x00FF, B=0x0001, op_sub=0 -> after 4 RUN cycles, done pulse with result=0x0100, carry_out=0, overflow=0; busy high for exactly 4 cycles.
- A=0xFFFF, B=0x0001, add -> result=0x0000, carry_out=1, overflow=0. A=0x7FFF, B=0x0001, add -> result=0x8000, carry_out=0, overflow=1.
- A=0x0005, B=0x0007, op_sub=1 -> result=0xFFFE, carry_out=0 (borrow), overflow=0. A=0x8000, B=0x0001, sub -> result=0x7FFF, overflow=1.
- Assert start with new operands during RUN cycle 2 -> ignored; first result unaffected. Then assert start in the done cycle -> accepted; second done arrives exactly K+1 cycles after the first.
- abort in RUN cycle 2 -> busy=0 next cycle and no done pulse. Then pull rst_n low mid-RUN of a new operation -> all outputs 0 immediately; a subsequent start completes correctly.

Source files
------------

// File: rtl/mpadd_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Holds the FSM state encoding and the operation select constants.
package mpadd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mpadd_seq_add_slice.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] carryChain;

  assign carryChain[0] = cin;

  for (genvar i = 0; i < W; i++) begin : gen_fa
    assign s[i]              = x[i] ^ y[i] ^ carryChain[i];
    assign carryChain[i + 1] = (x[i] & y[i]) | (carryChain[i] & (x[i] ^ y[i]));
  end

  assign cout  = carryChain[W];
  assign c_msb = carryChain[W-1];

endmodule

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: streams K words through one W-bit
// adder slice, least-significant word first, chaining the carry in a register.
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int W  = 4,
  parameter int K  = 4,
  parameter int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op_sub,
  input  logic           abort,
  input  logic [W*K-1:0] a_in,
  input  logic [W*K-1:0] b_in,
  output logic           busy,
  output logic           done,
  output logic [W*K-1:0] result,
  output logic           carry_out,
  output logic           overflow
);

  state_t         state, stateNext;
  logic [W*K-1:0] opA, opB;
  logic           carryReg;
  logic [IW-1:0]  idx;
  logic           lastWord;
  logic [W-1:0]   sliceX, sliceY, sliceSum;
  logic           sliceCout, sliceCmsb;

  assign lastWord = (idx == IW'(K - 1));
  assign sliceX   = opA[int'(idx)*W +: W];
  assign sliceY   = opB[int'(idx)*W +: W];

  add_slice #(.W(W)) uSlice (
    .x    (sliceX),
    .y    (sliceY),
    .cin  (carryReg),
    .s    (sliceSum),
    .cout (sliceCout),
    .c_msb(sliceCmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Abort takes priority over finishing the last word in RUN.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (start) stateNext = ST_RUN;
      ST_RUN: begin
        if (abort)         stateNext = ST_IDLE;
        else if (lastWord) stateNext = ST_DONE;
      end
      ST_DONE: stateNext = start ? ST_RUN : ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Subtraction is A + ~B + 1, so the inverted operand and carry-in are set at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA       <= '0;
      opB       <= '0;
      carryReg  <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state != ST_RUN) begin
      if (start) begin
        opA      <= a_in;
        opB      <= (op_sub == OP_SUB) ? ~b_in : b_in;
        carryReg <= op_sub;
        idx      <= '0;
        result   <= '0;
      end
    end else if (!abort) begin
      result[int'(idx)*W +: W] <= sliceSum;
      carryReg                 <= sliceCout;
      if (lastWord) begin
        carry_out <= sliceCout;
        overflow  <= sliceCmsb ^ sliceCout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpadd_seq.sv
// Self-checking bench for mpadd_seq: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mpadd_seq;

  localparam int W = 4;
  localparam int K = 4;
  localparam int N = W * K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, op_sub, abort;
  logic [N-1:0] a_in, b_in;
  logic         busy, done, carry_out, overflow;
  logic [N-1:0] result;

  int tests    = 0;
  int failures = 0;

  mpadd_seq #(.W(W), .K(K)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .abort    (abort),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: two's-complement arithmetic on whole integers, no word stepping.
  task automatic checkResult(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    longint sa, sb, sr;
    logic [N-1:0] expRes;
    logic expCarry, expOvf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      expRes   = a - b;
      expCarry = (a >= b);
      sr       = sa - sb;
    end else begin
      expRes   = a + b;
      expCarry = ({1'b0, a} + {1'b0, b}) > (2 ** N - 1);
      sr       = sa + sb;
    end
    expOvf = (sr > (2 ** (N - 1) - 1)) || (sr < -(2 ** (N - 1)));
    checkOutput({tag, "_result"}, 64'(result), 64'(expRes));
    checkOutput({tag, "_carry"}, 64'(carry_out), 64'(expCarry));
    checkOutput({tag, "_ovf"}, 64'(overflow), 64'(expOvf));
  endtask

  task automatic waitDone(output int cycles, output int busyCnt);
    cycles  = 0;
    busyCnt = 0;
    while (!done && cycles < 4 * K + 8) begin
      if (busy) busyCnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    int cycles, busyCnt;
    @(negedge clk);
    a_in = a; b_in = b; op_sub = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cycles, busyCnt);
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(K));
    checkOutput({tag, "_busycnt"}, 64'(busyCnt), 64'(K));
    checkResult(tag, a, b, sub);
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cycles, busyCnt;
    logic sawDone;
    logic [N-1:0] ra, rb;
    logic rs;

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; abort = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_carry", 64'(carry_out), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    applyStimulus("add_ff_1", 16'h00FF, 16'h0001, 1'b0);
    checkOutput("add_ff_1_const", 64'(result), 64'h0100);
    applyStimulus("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
    applyStimulus("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
    applyStimulus("sub_borrow", 16'h0005, 16'h0007, 1'b1);
    checkOutput("sub_borrow_const", 64'(result), 64'hFFFE);
    applyStimulus("sub_ovf", 16'h8000, 16'h0001, 1'b1);
    applyStimulus("sub_zero", 16'h0000, 16'h0000, 1'b1);
    applyStimulus("add_max", 16'h7FFF, 16'h7FFF, 1'b0);

    // Start during RUN cycle 2 must be ignored.
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hABCD; op_sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cycles, busyCnt);
    checkOutput("ign_latency", 64'(cycles), 64'(K - 2));
    checkResult("ign", 16'h1234, 16'h1111, 1'b0);

    // Back-to-back start in the done cycle.
    a_in = 16'h0F0F; b_in = 16'h00F1; op_sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cycles, busyCnt);
    checkOutput("b2b_gap", 64'(cycles + 1), 64'(K + 1));
    checkResult("b2b", 16'h0F0F, 16'h00F1, 1'b1);

    // Abort in RUN cycle 2.
    @(negedge clk);
    a_in = 16'h4321; b_in = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    sawDone = 1'b0;
    repeat (2 * K) begin
      @(negedge clk);
      sawDone |= done;
    end
    checkOutput("abort_nodone", 64'(sawDone), 64'd0);

    // Asynchronous reset mid-RUN.
    a_in = 16'h9999; b_in = 16'h7777; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_result", 64'(result), 64'd0);
    checkOutput("midrst_carry", 64'(carry_out), 64'd0);
    checkOutput("midrst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst", 16'hC3A5, 16'h5A3C, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rand%0d", i), ra, rb, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
